// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared definitions: stall vector layout,
// stall patterns, branch FSM states and enable constants.
package pipe_ctrl_pkg;

  localparam int STALL_W   = 6;
  localparam int ST_PC     = 0;
  localparam int ST_IF_ID  = 1;
  localparam int ST_ID_EX  = 2;
  localparam int ST_EX_MEM = 3;
  localparam int ST_MEM_WB = 4;
  localparam int ST_WB     = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_BR   = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } br_state_e;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl bundle: hazard/busy/branch status in,
// stall/flush controls and observability out.
interface pipe_ctrl_if #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  import pipe_ctrl_pkg::*;

  logic                  id_re1;
  logic                  id_re2;
  logic [REG_ADDR_W-1:0] id_raddr1;
  logic [REG_ADDR_W-1:0] id_raddr2;
  logic                  id_rsuc1;
  logic                  id_rsuc2;
  logic                  id_issue_load;
  logic [REG_ADDR_W-1:0] id_waddr;
  logic                  mem_we;
  logic [REG_ADDR_W-1:0] mem_waddr;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_waddr;
  logic                  if_busy;
  logic                  mem_busy;
  logic                  ex_branch;
  logic [STALL_W-1:0]    stall;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic [REG_NUM-1:0]    sb_pending;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_re1, id_re2, id_raddr1, id_raddr2,
    output id_rsuc1, id_rsuc2, id_issue_load, id_waddr,
    output mem_we, mem_waddr, wb_we, wb_waddr,
    output if_busy, mem_busy, ex_branch,
    input  stall, flush_if_id, flush_id_ex,
    input  sb_pending, stall_cnt
  );

  modport slave (
    input  id_re1, id_re2, id_raddr1, id_raddr2,
    input  id_rsuc1, id_rsuc2, id_issue_load, id_waddr,
    input  mem_we, mem_waddr, wb_we, wb_waddr,
    input  if_busy, mem_busy, ex_branch,
    output stall, flush_if_id, flush_id_ex,
    output sb_pending, stall_cnt
  );

endinterface

// File: rtl/pipe_scoreboard.sv
// Pending-load bitmap: one bit per register with an
// outstanding load, set on issue, cleared on writeback.
module pipe_scoreboard #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic                  pend1_o,
  output logic                  pend2_o,
  output logic [REG_NUM-1:0]    pending_o
);
  import pipe_ctrl_pkg::*;

  logic [REG_NUM-1:0] pend_q;
  logic [REG_NUM-1:0] pend_d;

  // clear applied first so a same-cycle set wins
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) pend_q <= '0;
    else                  pend_q <= pend_d;
  end

  assign pend1_o   = pend_q[raddr1_i];
  assign pend2_o   = pend_q[raddr2_i];
  assign pending_o = pend_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush priority, branch wait
// FSM across memory stalls, and stall-cycle counter.
module pipe_ctrl #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  import pipe_ctrl_pkg::*;

  br_state_e          state_q;
  br_state_e          state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [STALL_W-1:0] stall;
  logic               fl_if;
  logic               fl_ex;
  logic               br_eff;
  logic               pend1;
  logic               pend2;
  logic               haz1;
  logic               haz2;
  logic               sb_set;
  logic               sb_clr;

  assign sb_set = bus.id_issue_load & ~stall[ST_ID_EX] & ~fl_ex;
  assign sb_clr = bus.wb_we == WriteEnable;

  pipe_scoreboard #(
    .REG_NUM    (REG_NUM),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set),
    .set_addr_i (bus.id_waddr),
    .clr_i      (sb_clr),
    .clr_addr_i (bus.wb_waddr),
    .raddr1_i   (bus.id_raddr1),
    .raddr2_i   (bus.id_raddr2),
    .pend1_o    (pend1),
    .pend2_o    (pend2),
    .pending_o  (bus.sb_pending)
  );

  // a pending load is satisfied once MEM or WB can forward it
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    if (bus.id_re1 == ReadEnable && bus.id_raddr1 != '0)
      haz1 = ~bus.id_rsuc1 | (pend1
        & ~(bus.mem_we & (bus.mem_waddr == bus.id_raddr1))
        & ~(bus.wb_we & (bus.wb_waddr == bus.id_raddr1)));
    if (bus.id_re2 == ReadEnable && bus.id_raddr2 != '0)
      haz2 = ~bus.id_rsuc2 | (pend2
        & ~(bus.mem_we & (bus.mem_waddr == bus.id_raddr2))
        & ~(bus.wb_we & (bus.wb_waddr == bus.id_raddr2)));
  end

  always_comb begin
    state_d = state_q;
    br_eff  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_branch && bus.mem_busy) state_d = BR_WAIT;
        br_eff = bus.ex_branch & ~bus.mem_busy;
      end
      BR_WAIT: begin
        if (!bus.mem_busy) state_d = RUN;
        br_eff = ~bus.mem_busy;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall = STALL_NONE;
    fl_if = 1'b0;
    fl_ex = 1'b0;
    if (rst == RstEnable) begin
      stall = STALL_NONE;
    end else if (bus.mem_busy) begin
      stall = STALL_MEM;
    end else if (br_eff) begin
      stall = STALL_BR;
      fl_if = 1'b1;
      fl_ex = 1'b1;
    end else if (haz1 | haz2) begin
      stall = STALL_ID;
      fl_ex = 1'b1;
    end else if (bus.if_busy) begin
      stall = STALL_IF;
      fl_if = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall[ST_PC] && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.flush_if_id = fl_if;
  assign bus.flush_id_ex = fl_ex;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int RN = 32;
  localparam int AW = 5;
  localparam int CW = 10;
  localparam logic [CW-1:0] CMAX = '1;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;
    logic [31:0] val;
    logic        fi;
    logic        fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q[$];
  exp_t e;
  logic [5:0]    cur_st;
  logic [CW-1:0] cnt_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_ctrl_if #(.REG_NUM(RN), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  pipe_ctrl #(.REG_NUM(RN), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      case (e.kind)
        0: if (bus.stall == e.val[5:0] && bus.flush_if_id == e.fi
               && bus.flush_id_ex == e.fe) passed++;
           else $display("FAIL %s: got stall=%b fi=%b fe=%b want stall=%b fi=%b fe=%b",
                         e.name, bus.stall, bus.flush_if_id, bus.flush_id_ex,
                         e.val[5:0], e.fi, e.fe);
        1: if (bus.sb_pending == e.val) passed++;
           else $display("FAIL %s: got sb_pending=%h want %h",
                         e.name, bus.sb_pending, e.val);
        default:
           if (bus.stall_cnt == e.val[CW-1:0]) passed++;
           else $display("FAIL %s: got stall_cnt=%0d want %0d",
                         e.name, bus.stall_cnt, e.val[CW-1:0]);
      endcase
    end
  end

  task automatic idle();
    bus.id_re1 = 0; bus.id_re2 = 0;
    bus.id_raddr1 = '0; bus.id_raddr2 = '0;
    bus.id_rsuc1 = 1; bus.id_rsuc2 = 1;
    bus.id_issue_load = 0; bus.id_waddr = '0;
    bus.mem_we = 0; bus.mem_waddr = '0;
    bus.wb_we = 0; bus.wb_waddr = '0;
    bus.if_busy = 0; bus.mem_busy = 0; bus.ex_branch = 0;
  endtask

  task automatic step();
    if (rst) cnt_m = '0;
    else if (cur_st[0] && cnt_m != CMAX) cnt_m = cnt_m + 1'b1;
    cur_st = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_o(string n, logic [5:0] st, logic fi, logic fe);
    q.push_back('{cyc, n, 0, {26'b0, st}, fi, fe});
    cur_st = st;
  endtask

  task automatic exp_sb(string n, logic [31:0] v);
    q.push_back('{cyc, n, 1, v, 1'b0, 1'b0});
  endtask

  task automatic exp_cnt(string n, logic [CW-1:0] v);
    q.push_back('{cyc, n, 2, {{(32-CW){1'b0}}, v}, 1'b0, 1'b0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_st = '0;
    cnt_m  = '0;
    rst = 1;
    idle();
    step();
    bus.mem_busy = 1; bus.if_busy = 1; bus.ex_branch = 1;
    exp_o("rst_out", STALL_NONE, 0, 0);
    step();
    exp_o("rst_out2", STALL_NONE, 0, 0);
    exp_sb("rst_sb", 32'h0);
    exp_cnt("rst_cnt", cnt_m);
    step();
    rst = 0; idle();
    exp_o("idle", STALL_NONE, 0, 0);
    step();
    bus.id_issue_load = 1; bus.id_waddr = 5;
    exp_o("load_issue", STALL_NONE, 0, 0);
    step();
    idle();
    bus.id_re1 = 1; bus.id_raddr1 = 5;
    bus.id_issue_load = 1; bus.id_waddr = 6;
    exp_o("raw_hazard", STALL_ID, 0, 1);
    exp_sb("sb5_set", 32'h20);
    step();
    bus.id_issue_load = 0;
    bus.mem_we = 1; bus.mem_waddr = 5;
    exp_o("mem_fwd", STALL_NONE, 0, 0);
    exp_sb("flushed_load", 32'h20);
    step();
    bus.mem_we = 0; bus.wb_we = 1; bus.wb_waddr = 5;
    exp_o("wb_fwd", STALL_NONE, 0, 0);
    step();
    idle();
    exp_sb("sb5_clr", 32'h0);
    exp_cnt("cnt_hazard", cnt_m);
    step();
    bus.id_re2 = 1; bus.id_raddr2 = 0; bus.id_rsuc2 = 0;
    exp_o("x0_rsuc", STALL_NONE, 0, 0);
    step();
    bus.id_raddr2 = 3;
    exp_o("rsuc_fail", STALL_ID, 0, 1);
    step();
    bus.id_re2 = 0;
    exp_o("rsuc_disabled", STALL_NONE, 0, 0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.ex_branch = 1; bus.mem_busy = 1;
      exp_o("br_wait", STALL_MEM, 0, 0);
      step();
    end
    idle();
    exp_o("br_release", STALL_BR, 1, 1);
    step();
    exp_o("br_run", STALL_NONE, 0, 0);
    step();
    bus.ex_branch = 1; bus.if_busy = 1;
    bus.id_re1 = 1; bus.id_raddr1 = 9; bus.id_rsuc1 = 0;
    bus.id_issue_load = 1; bus.id_waddr = 9;
    exp_o("br_over_all", STALL_BR, 1, 1);
    step();
    idle();
    bus.if_busy = 1;
    exp_sb("br_no_load", 32'h0);
    exp_o("if_busy", STALL_IF, 1, 0);
    step();
    bus.id_re1 = 1; bus.id_raddr1 = 4; bus.id_rsuc1 = 0;
    exp_o("id_over_if", STALL_ID, 0, 1);
    step();
    bus.mem_busy = 1;
    exp_o("mem_over_id", STALL_MEM, 0, 0);
    step();
    idle();
    bus.id_issue_load = 1; bus.id_waddr = 7;
    bus.wb_we = 1; bus.wb_waddr = 7;
    exp_o("set_clr", STALL_NONE, 0, 0);
    step();
    idle();
    bus.id_issue_load = 1; bus.id_waddr = 0;
    exp_sb("set_wins", 32'h80);
    step();
    idle();
    bus.id_re2 = 1; bus.id_raddr2 = 7;
    exp_sb("x0_load", 32'h80);
    exp_o("pend_x7", STALL_ID, 0, 1);
    step();
    bus.id_re1 = 1; bus.id_raddr1 = 0; bus.id_rsuc1 = 0;
    bus.wb_we = 1; bus.wb_waddr = 7;
    exp_o("wb_fwd_x7", STALL_NONE, 0, 0);
    step();
    idle();
    exp_sb("sb7_clr", 32'h0);
    exp_cnt("cnt_pre_sat", cnt_m);
    step();
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      bus.if_busy = 1;
      cur_st = STALL_IF;
      step();
    end
    idle();
    exp_cnt("cnt_sat", CMAX);
    exp_o("if_off", STALL_NONE, 0, 0);
    step();
    bus.ex_branch = 1; bus.mem_busy = 1;
    bus.id_issue_load = 1; bus.id_waddr = 12;
    exp_o("pre_rst_wait", STALL_MEM, 0, 0);
    step();
    rst = 1;
    exp_o("rst_mid", STALL_NONE, 0, 0);
    step();
    rst = 0; idle();
    exp_o("br_dropped", STALL_NONE, 0, 0);
    exp_cnt("cnt_rst", 0);
    exp_sb("sb_rst", 32'h0);
    step();
    step();
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      $display("FAIL %s: got unchecked want checked", e.name);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage RISC-V core. It decides, every cycle, which pipeline registers hold and which get a bubble. Its inputs are:
- regfile read status and a load-destination scoreboard,
- fetch and memory busy signals,
- EX-stage taken branches.

It sits beside the regfile and drives the stall and flush inputs of pc_reg, if_id, id_ex, ex_mem and mem_wb.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers.
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- id_re1, id_re2  in  1  ID read enables for rs1 and rs2.
- id_raddr1, id_raddr2  in  REG_ADDR_W  ID source addresses.
- id_rsuc1, id_rsuc2  in  1  regfile read-success flags.
- id_issue_load  in  1  ID is handing a load to EX this cycle.
- id_waddr  in  REG_ADDR_W  destination of that load.
- mem_we, mem_waddr  in  1 / REG_ADDR_W  MEM-stage forwardable write.
- wb_we, wb_waddr  in  1 / REG_ADDR_W  writeback port.
- if_busy  in  1  fetch not complete.
- mem_busy  in  1  load/store not complete.
- ex_branch  in  1  EX resolved a taken branch or jump.
- stall  out  6  hold enables: [0] pc, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
- flush_if_id, flush_id_ex  out  1  load a bubble into that register.
- sb_pending  out  REG_NUM  scoreboard contents (observability).
- stall_cnt  out  CNT_W  saturating count of cycles with stall[0]=1.

## Operation
Scoreboard (registered):
- On an accepted load issue (id_issue_load && !stall[2] && !flush_id_ex), set pending[id_waddr].
- Clear pending[wb_waddr] when wb_we is asserted.
- If set and clear hit the same address in the same cycle, set wins.
- Bit 0 is never set.

ID hazard, per enabled source n with a nonzero address. hazard_n is 1 when either:
- !id_rsucn, or
- pending[raddrn] is set and neither (mem_we && mem_waddr==raddrn) nor (wb_we && wb_waddr==raddrn) holds.

id_hazard = hazard_1 | hazard_2.

Stall priority, highest first:
1. mem_busy → stall=6'b011111.
2. Effective branch → stall=0, flush_if_id=1, flush_id_ex=1. This overrides id_hazard and if_busy.
3. id_hazard → stall=6'b000111, flush_id_ex=1 (bubble into EX).
4. if_busy → stall=6'b000011, flush_if_id=1.
5. Otherwise stall=0, no flush.

Branch FSM, states RUN and BR_WAIT:
- RUN: ex_branch && !mem_busy is an effective branch this cycle. ex_branch && mem_busy goes to BR_WAIT with no flush.
- BR_WAIT: holds while mem_busy. The first cycle with !mem_busy is an effective branch, then return to RUN.
- ex_branch in BR_WAIT is the same held instruction and is ignored.

stall_cnt increments on every cycle with stall[0]=1 and saturates at all-ones.

## Timing
- stall and flush outputs are combinational from inputs and state; there is no added latency.
- Scoreboard, FSM and counter update on posedge clk.
- A load issued in cycle t is visible in sb_pending at t+1. It clears the cycle after its writeback.
- Reset (synchronous, any cycle including mid-stall or BR_WAIT):
  - pending=0, state=RUN, stall_cnt=0;
  - while rst=1: stall=0, flush_if_id=0, flush_id_ex=0.
- A pending branch is dropped on reset.
- Register 0 never causes a hazard.
- Scoreboard set plus clear of the same register in one cycle leaves the bit set.

## Structure
- Shared package/defs: stall vector width and bit indices, the five stall patterns, FSM state encodings, RstEnable/WriteEnable/ReadEnable constants.
- One natural sub-module, pipe_scoreboard: the pending bitmap with set/clear ports and two combinational lookups.
- Priority logic, FSM and counter live in pipe_ctrl.

## Test plan
- Load x5 issued, next instruction reads x5 with mem_we=0 → stall=000111, flush_id_ex=1. mem_we=1/mem_waddr=5 → stall=0. After wb of x5 → sb_pending[5]=0.
- id_rsuc2=0 with id_raddr2=0 → no hazard, stall=0. id_rsuc2=0 with id_raddr2=3, re2=1 → stall=000111.
- ex_branch with mem_busy=1 for 3 cycles → stall=011111 and no flush for 3 cycles. Next cycle flush_if_id=flush_id_ex=1, then state returns to RUN.
- ex_branch and id_hazard and if_busy together → stall=0, both flushes=1.
- Issue load to x7 and wb x7 in the same cycle → sb_pending[7]=1. Load to x0 → bit 0 stays 0.
- Hold if_busy for 2^CNT_W+5 cycles → stall_cnt saturates at all-ones. rst for 1 cycle → stall_cnt=0, sb_pending=0, outputs 0 during rst.
